// File: rtl/cache_bank_arbiter.sv
// Round-robin arbiter sharing one dual-port cache bank among NUM_REQ requesters, with same-line hazard blocking.
// Define CACHE_ARB_PERF_EN to add the perf_grants / perf_conflicts counters.
`ifndef CACHE_BANK_ADDRESS_WIDTH
`define CACHE_BANK_ADDRESS_WIDTH 10
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module cache_bank_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = `CACHE_BANK_ADDRESS_WIDTH,
    parameter int DATA_W  = `DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_gnt,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [NUM_REQ*DATA_W-1:0]   rsp_data,
    output logic [NUM_REQ-1:0]          rsp_written,
`ifdef CACHE_ARB_PERF_EN
    output logic [31:0]                 perf_grants,
    output logic [31:0]                 perf_conflicts,
`endif
    output logic [ADDR_W-1:0]           bank_addr_A,
    output logic [ADDR_W-1:0]           bank_addr_B,
    output logic [DATA_W-1:0]           bank_din_A,
    output logic [DATA_W-1:0]           bank_din_B,
    output logic                        bank_we_n_A,
    output logic                        bank_we_n_B,
    input  logic [DATA_W-1:0]           bank_dout_A,
    input  logic [DATA_W-1:0]           bank_dout_B,
    input  logic                        bank_wr_A,
    input  logic                        bank_wr_B
);
    localparam int ID_W = $clog2(NUM_REQ);
    typedef logic [ID_W-1:0] id_t;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0] conflict_a;

    id_t  rr_ptr_reg, rr_ptr_next;
    logic a_found, b_found;
    id_t  a_id, b_id, last_id;
    id_t  scan_a_idx, scan_b_idx;
    logic past_a;

    logic tag_a_valid_reg, tag_b_valid_reg;
    id_t  tag_a_id_reg, tag_b_id_reg;

    // Position k of the round-robin scan starting at base.
    function automatic id_t rot_idx(input id_t base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return id_t'(s);
    endfunction

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign addr_arr[gi]   = req_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi]  = req_wdata[gi*DATA_W +: DATA_W];
        assign conflict_a[gi] = a_found && (addr_arr[gi] == addr_arr[a_id])
                                && (req_we[gi] || req_we[a_id]);
    end

    // Port A: first valid requester in round-robin order.
    always_comb begin
        a_found    = 1'b0;
        a_id       = '0;
        scan_a_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_a_idx = rot_idx(rr_ptr_reg, k);
            if (!a_found && !reset && req_valid[scan_a_idx]) begin
                a_found = 1'b1;
                a_id    = scan_a_idx;
            end
        end
    end

`ifdef CACHE_ARB_PERF_EN
    logic skipped;
`endif

    // Port B: continue the scan past A, skipping requesters that would hazard with A.
    always_comb begin
        b_found    = 1'b0;
        b_id       = '0;
        past_a     = 1'b0;
        scan_b_idx = '0;
`ifdef CACHE_ARB_PERF_EN
        skipped    = 1'b0;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_b_idx = rot_idx(rr_ptr_reg, k);
            if (past_a && !b_found && req_valid[scan_b_idx]) begin
                if (conflict_a[scan_b_idx]) begin
`ifdef CACHE_ARB_PERF_EN
                    skipped = 1'b1;
`endif
                end else begin
                    b_found = 1'b1;
                    b_id    = scan_b_idx;
                end
            end
            if (a_found && (scan_b_idx == a_id)) begin
                past_a = 1'b1;
            end
        end
    end

    always_comb begin
        req_gnt     = '0;
        bank_addr_A = '0;
        bank_din_A  = '0;
        bank_we_n_A = 1'b1;
        bank_addr_B = '0;
        bank_din_B  = '0;
        bank_we_n_B = 1'b1;
        if (a_found) begin
            req_gnt[a_id] = 1'b1;
            bank_addr_A   = addr_arr[a_id];
            if (req_we[a_id]) begin
                bank_we_n_A = 1'b0;
                bank_din_A  = wdata_arr[a_id];
            end
        end
        if (b_found) begin
            req_gnt[b_id] = 1'b1;
            bank_addr_B   = addr_arr[b_id];
            if (req_we[b_id]) begin
                bank_we_n_B = 1'b0;
                bank_din_B  = wdata_arr[b_id];
            end
        end
    end

    // Priority moves just past the last requester granted this cycle.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        last_id     = b_found ? b_id : a_id;
        if (a_found) begin
            rr_ptr_next = (last_id == id_t'(NUM_REQ - 1)) ? '0 : last_id + id_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_reg      <= '0;
            tag_a_valid_reg <= 1'b0;
            tag_b_valid_reg <= 1'b0;
            tag_a_id_reg    <= '0;
            tag_b_id_reg    <= '0;
        end else begin
            rr_ptr_reg      <= rr_ptr_next;
            tag_a_valid_reg <= a_found && !req_we[a_id];
            tag_b_valid_reg <= b_found && !req_we[b_id];
            tag_a_id_reg    <= a_id;
            tag_b_id_reg    <= b_id;
        end
    end

    // Bank read data arrives one cycle after the grant; steer it by the stored tag.
    always_comb begin
        rsp_valid   = '0;
        rsp_data    = '0;
        rsp_written = '0;
        if (tag_a_valid_reg && !reset) begin
            rsp_valid[tag_a_id_reg]                           = 1'b1;
            rsp_data[int'(tag_a_id_reg)*DATA_W +: DATA_W]     = bank_dout_A;
            rsp_written[tag_a_id_reg]                         = bank_wr_A;
        end
        if (tag_b_valid_reg && !reset) begin
            rsp_valid[tag_b_id_reg]                           = 1'b1;
            rsp_data[int'(tag_b_id_reg)*DATA_W +: DATA_W]     = bank_dout_B;
            rsp_written[tag_b_id_reg]                         = bank_wr_B;
        end
    end

`ifdef CACHE_ARB_PERF_EN
    logic [31:0] perf_grants_reg, perf_conflicts_reg;
    logic [1:0]  grant_cnt;

    assign grant_cnt = {1'b0, a_found} + {1'b0, b_found};

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_grants_reg    <= '0;
            perf_conflicts_reg <= '0;
        end else begin
            if (perf_grants_reg > (32'hFFFF_FFFF - {30'd0, grant_cnt})) begin
                perf_grants_reg <= '1;
            end else begin
                perf_grants_reg <= perf_grants_reg + {30'd0, grant_cnt};
            end
            if (skipped && (perf_conflicts_reg != '1)) begin
                perf_conflicts_reg <= perf_conflicts_reg + 32'd1;
            end
        end
    end

    assign perf_grants    = perf_grants_reg;
    assign perf_conflicts = perf_conflicts_reg;
`endif

endmodule
